// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared constants and FSM state encoding for the mantissa add/sub path
//
// Purpose: default operand/chunk widths and the IDLE/BUSY/DONE state type
//          used by mantissa_addsub_seq.
package fpu_pkg;

  localparam int DEFAULT_WIDTH = 24;
  localparam int DEFAULT_CHUNK = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/chunk_adder.sv
// rtl/chunk_adder.sv - combinational W-bit ripple adder built from full_adder cells
//
// Purpose: adds one chunk of the mantissa per cycle.
// Ports:   a, b [W-1:0] - chunk operands
//          cin          - carry into bit 0
//          sum [W-1:0]  - chunk sum
//          cout         - carry out of bit W-1
module chunk_adder #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < W; i++) begin : g_bit
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (carry[i]),
      .sum  (sum[i]),
      .cout (carry[i+1])
    );
  end

  assign cout = carry[W];

endmodule

// File: rtl/full_adder.sv
// rtl/full_adder.sv - single-bit full adder cell
//
// Purpose: one-bit a + b + cin.
// Ports:   a, b, cin - addend bits and carry-in
//          sum, cout - sum bit and carry-out
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/mantissa_addsub_seq.sv
// rtl/mantissa_addsub_seq.sv - multi-cycle mantissa adder/subtractor, CHUNK bits per cycle
//
// Purpose: computes a+b+cin or a-b over WIDTH/CHUNK cycles with a valid/ready
//          handshake on both sides.
// Ports:   clk, rst             - clock, synchronous active-high reset
//          in_valid, in_ready   - operand handshake (ready only in IDLE)
//          a, b [WIDTH-1:0]     - unsigned operands
//          sub, cin             - 1 = a-b; carry-in used only when sub=0
//          out_valid, out_ready - result handshake (valid only in DONE)
//          sum [WIDTH-1:0]      - result modulo 2^WIDTH
//          cout                 - carry out of MSB (sub: 1 = no borrow)
//          zero                 - sum is all zeros
module mantissa_addsub_seq
  import fpu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CHUNK = DEFAULT_CHUNK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             zero
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_chunk
    $error("mantissa_addsub_seq: WIDTH must be a positive multiple of CHUNK");
  end

  state_t           state, state_next;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic             carry;
  logic [IDX_W-1:0] idx;
  logic [CHUNK-1:0] chunk_a, chunk_b, chunk_sum;
  logic             chunk_cout;
  logic [WIDTH-1:0] sum_merged;
  logic             accept, last_chunk;

  // ---------------- control FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = BUSY;
      end
      BUSY: begin
        if (idx == LAST_IDX) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign accept     = (state == IDLE) && in_valid;
  assign last_chunk = (state == BUSY) && (idx == LAST_IDX);

  // ---------------- datapath ----------------
  assign chunk_a = a_reg[idx*CHUNK +: CHUNK];
  assign chunk_b = b_reg[idx*CHUNK +: CHUNK];

  chunk_adder #(.W(CHUNK)) u_chunk_adder (
    .a    (chunk_a),
    .b    (chunk_b),
    .cin  (carry),
    .sum  (chunk_sum),
    .cout (chunk_cout)
  );

  // Result with the current chunk spliced in, so zero can be judged on the
  // final value in the same cycle the last chunk lands.
  always_comb begin
    sum_merged = sum;
    sum_merged[idx*CHUNK +: CHUNK] = chunk_sum;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg <= '0;
      b_reg <= '0;
      carry <= 1'b0;
      idx   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      zero  <= 1'b0;
    end else if (accept) begin
      // Subtraction as a + ~b + 1.
      a_reg <= a;
      b_reg <= sub ? ~b : b;
      carry <= sub ? 1'b1 : cin;
      idx   <= '0;
    end else if (state == BUSY) begin
      sum   <= sum_merged;
      carry <= chunk_cout;
      idx   <= last_chunk ? '0 : idx + 1'b1;
      if (last_chunk) begin
        cout <= chunk_cout;
        zero <= (sum_merged == '0);
      end
    end
  end

endmodule

// File: tb/tb_mantissa_addsub_seq.sv
// tb/tb_mantissa_addsub_seq.sv - self-checking bench for mantissa_addsub_seq
module tb_mantissa_addsub_seq;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, sub, cin, out_ready;
  logic [23:0] a, b;
  logic        in_ready, out_valid, cout, zero;
  logic [23:0] sum;

  logic        in_valid_f, sub_f, cin_f, out_ready_f;
  logic [23:0] a_f, b_f;
  logic        in_ready_f, out_valid_f, cout_f, zero_f;
  logic [23:0] sum_f;

  int vectors    = 0;
  int miscompares = 0;

  mantissa_addsub_seq #(.WIDTH(24), .CHUNK(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .zero(zero)
  );

  mantissa_addsub_seq #(.WIDTH(24), .CHUNK(24)) dut_full (
    .clk(clk), .rst(rst), .in_valid(in_valid_f), .in_ready(in_ready_f),
    .a(a_f), .b(b_f), .sub(sub_f), .cin(cin_f),
    .out_valid(out_valid_f), .out_ready(out_ready_f),
    .sum(sum_f), .cout(cout_f), .zero(zero_f)
  );

  // Reference: {cout, sum} from integer arithmetic; subtraction borrows 2^24.
  function automatic logic [25:0] model(input logic s, input logic [23:0] x, input logic [23:0] y,
                                        input logic c);
    logic [24:0] r;
    if (s) r = 25'h1000000 + {1'b0, x} - {1'b0, y};
    else   r = {1'b0, x} + {1'b0, y} + {24'd0, c};
    return {r[24], (r[23:0] == 24'd0), r[23:0]};
  endfunction

  task automatic run_op(input logic s, input logic [23:0] x, input logic [23:0] y, input logic c,
                        output logic [25:0] res, output int lat);
    int n = 0;
    a = x; b = y; sub = s; cin = c; in_valid = 1'b1;
    while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = $urandom; b = $urandom;
    lat = 0;
    while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    res = {cout, zero, sum};
  endtask

  task automatic run_op_f(input logic s, input logic [23:0] x, input logic [23:0] y, input logic c,
                          output logic [25:0] res, output int lat);
    int n = 0;
    a_f = x; b_f = y; sub_f = s; cin_f = c; in_valid_f = 1'b1;
    while (!in_ready_f && n < 20) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    in_valid_f = 1'b0;
    lat = 0;
    while (!out_valid_f && lat < 20) begin @(posedge clk); #1; lat++; end
    res = {cout_f, zero_f, sum_f};
    out_ready_f = 1'b1;
    @(posedge clk); #1;
    out_ready_f = 1'b0;
  endtask

  task automatic finish_op();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_valid_f = 1'b1;
    a = 24'h123456; b = 24'h654321;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({in_ready, out_valid, cout, zero, sum} !== {1'b1, 1'b0, 1'b0, 1'b0, 24'd0}) begin
      miscompares++;
      $display("FAIL reset_state got rdy=%b vld=%b c=%b z=%b s=%h exp 1 0 0 0 000000",
               in_ready, out_valid, cout, zero, sum);
    end
    vectors++;
    if ({in_ready_f, out_valid_f, sum_f} !== {1'b1, 1'b0, 24'd0}) begin
      miscompares++;
      $display("FAIL reset_state_full got rdy=%b vld=%b s=%h exp 1 0 000000",
               in_ready_f, out_valid_f, sum_f);
    end
    rst = 1'b0; in_valid = 1'b0; in_valid_f = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [23:0] xs[4] = '{24'h000001, 24'h7FFFFF, 24'h800000, 24'h000001};
    logic [23:0] ys[4] = '{24'hFFFFFF, 24'h000000, 24'h000001, 24'h000002};
    logic        ss[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic        cs[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [25:0] ex[4] = '{{1'b1, 1'b1, 24'h000000}, {1'b0, 1'b0, 24'h800000},
                           {1'b1, 1'b0, 24'h7FFFFF}, {1'b0, 1'b0, 24'hFFFFFF}};
    logic [25:0] res;
    int lat;
    for (int i = 0; i < 4; i++) begin
      run_op(ss[i], xs[i], ys[i], cs[i], res, lat);
      vectors++;
      if (res !== ex[i]) begin
        miscompares++;
        $display("FAIL directed_%0d got c/z/sum=%h exp %h", i, res, ex[i]);
      end
      vectors++;
      if (lat !== 3) begin
        miscompares++;
        $display("FAIL directed_latency_%0d got %0d exp 3", i, lat);
      end
      finish_op();
    end
  endtask

  task automatic test_backpressure();
    logic [25:0] res, held;
    int lat;
    int bad = 0;
    run_op(1'b0, 24'h00F00F, 24'h0F00F0, 1'b1, res, lat);
    held = model(1'b0, 24'h00F00F, 24'h0F00F0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1; a = $urandom; b = $urandom; sub = k[0];
      @(posedge clk); #1;
      if ({cout, zero, sum} !== held || out_valid !== 1'b1 || in_ready !== 1'b0) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL backpressure_hold got %0d unstable cycles exp 0 (last c/z/sum=%h exp %h)",
               bad, {cout, zero, sum}, held);
    end
    in_valid = 1'b0;
    finish_op();
    vectors++;
    if ({in_ready, out_valid, cout, zero, sum} !== {1'b1, 1'b0, held}) begin
      miscompares++;
      $display("FAIL backpressure_release got rdy=%b vld=%b c/z/sum=%h exp 1 0 %h",
               in_ready, out_valid, {cout, zero, sum}, held);
    end
  endtask

  task automatic test_reset_mid_busy();
    logic [25:0] res;
    int lat;
    int seen = 0;
    a = 24'hABCDEF; b = 24'h111111; sub = 1'b0; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    vectors++;
    if ({in_ready, out_valid, cout, zero, sum} !== {1'b1, 1'b0, 1'b0, 1'b0, 24'd0}) begin
      miscompares++;
      $display("FAIL reset_mid_busy got rdy=%b vld=%b c=%b z=%b s=%h exp 1 0 0 0 000000",
               in_ready, out_valid, cout, zero, sum);
    end
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    vectors++;
    if (seen != 0) begin
      miscompares++;
      $display("FAIL aborted_output got %0d valid cycles exp 0", seen);
    end
    run_op(1'b0, 24'h000010, 24'h000020, 1'b0, res, lat);
    vectors++;
    if (res !== {1'b0, 1'b0, 24'h000030} || lat !== 3) begin
      miscompares++;
      $display("FAIL post_reset_op got c/z/sum=%h lat=%0d exp %h lat=3",
               res, lat, {1'b0, 1'b0, 24'h000030});
    end
    finish_op();
  endtask

  task automatic test_reset_priority();
    logic [25:0] res;
    int lat;
    run_op(1'b0, 24'h000005, 24'h000007, 1'b0, res, lat);
    out_ready = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0; rst = 1'b0;
    vectors++;
    if ({in_ready, out_valid, sum} !== {1'b1, 1'b0, 24'd0}) begin
      miscompares++;
      $display("FAIL reset_priority got rdy=%b vld=%b s=%h exp 1 0 000000",
               in_ready, out_valid, sum);
    end
  endtask

  task automatic test_random();
    logic [25:0] res, ex;
    logic [23:0] x, y;
    logic s, c;
    int lat, hold;
    for (int i = 0; i < 40; i++) begin
      x = $urandom; y = $urandom; s = $urandom_range(0, 1); c = $urandom_range(0, 1);
      if (i % 8 == 0) y = x;
      if (i % 8 == 1) y = ~x;
      ex = model(s, x, y, c);
      run_op(s, x, y, c, res, lat);
      vectors++;
      if (res !== ex || lat !== 3) begin
        miscompares++;
        $display("FAIL random_%0d op s=%b a=%h b=%h cin=%b got c/z/sum=%h lat=%0d exp %h lat=3",
                 i, s, x, y, c, res, lat, ex);
      end
      hold = $urandom_range(0, 3);
      repeat (hold) begin
        in_valid = $urandom_range(0, 1); a = $urandom;
        @(posedge clk); #1;
      end
      in_valid = 1'b0;
      vectors++;
      if ({cout, zero, sum} !== ex || out_valid !== 1'b1) begin
        miscompares++;
        $display("FAIL random_hold_%0d got c/z/sum=%h vld=%b exp %h vld=1",
                 i, {cout, zero, sum}, out_valid, ex);
      end
      finish_op();
    end
  endtask

  task automatic test_chunk_full();
    logic [25:0] res, ex;
    logic [23:0] x, y;
    logic s, c;
    int lat;
    run_op_f(1'b0, 24'hFFFFFF, 24'h000001, 1'b0, res, lat);
    vectors++;
    if (res !== {1'b1, 1'b1, 24'h000000} || lat !== 1) begin
      miscompares++;
      $display("FAIL full_chunk_wrap got c/z/sum=%h lat=%0d exp %h lat=1",
               res, lat, {1'b1, 1'b1, 24'h000000});
    end
    for (int i = 0; i < 10; i++) begin
      x = $urandom; y = $urandom; s = $urandom_range(0, 1); c = $urandom_range(0, 1);
      ex = model(s, x, y, c);
      run_op_f(s, x, y, c, res, lat);
      vectors++;
      if (res !== ex || lat !== 1) begin
        miscompares++;
        $display("FAIL full_chunk_random_%0d got c/z/sum=%h lat=%0d exp %h lat=1",
                 i, res, lat, ex);
      end
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; sub = 1'b0; cin = 1'b0; out_ready = 1'b0;
    a = '0; b = '0;
    in_valid_f = 1'b0; sub_f = 1'b0; cin_f = 1'b0; out_ready_f = 1'b0;
    a_f = '0; b_f = '0;
    #1;
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_busy();
    test_reset_priority();
    test_random();
    test_chunk_full();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
